// File: rtl/mac_datapath.sv
// Multiply-accumulate datapath for a fixed-point (Q8.8) neural network.
// Reads a neuron/weight pair per cycle, accumulates Q16.16 products, and on
// the last term of a neuron shifts, saturates, activates and writes the
// result back to neuron memory. Recently written values are forwarded to
// reads that would otherwise see stale memory data.
module mac_datapath #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       input_neuron_addr,
  input  logic [15:0]       input_weight_addr,
  input  logic [11:0]       output_neuron_addr,
  input  logic              reset_mult_acc,
  input  logic              write_neuron,
  input  logic              done,
  output logic [11:0]       neuron_rd_addr,
  input  logic [DATA_W-1:0] neuron_rd_data,
  output logic [15:0]       weight_rd_addr,
  input  logic [DATA_W-1:0] weight_rd_data,
  output logic              neuron_wr_en,
  output logic [11:0]       neuron_wr_addr,
  output logic [DATA_W-1:0] neuron_wr_data,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  output logic              sat_flag
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Control aligned with the read data (one cycle behind the address)
  logic              r_rst_acc;
  logic              r_wr;
  logic              r_done;
  logic [11:0]       r_out_addr;
  // Forwarding capture for the read issued last cycle
  logic              r_fwd_sel;
  logic [DATA_W-1:0] r_fwd_data;
  // Accumulator
  logic signed [ACC_W-1:0] r_acc;
  logic              r_clr_next;
  // Write register and results
  logic              r_wr_en;
  logic [11:0]       r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_final;
  logic              r_result_valid;
  logic [DATA_W-1:0] r_result_data;
  logic              r_sat;

  logic signed [DATA_W-1:0] w_n_op;
  logic signed [PROD_W-1:0] w_n_ext;
  logic signed [PROD_W-1:0] w_w_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_shift;
  logic                     w_hi;
  logic                     w_lo;
  logic [DATA_W-1:0]        w_clamped;
  logic [DATA_W-1:0]        w_result;
  logic                     w_fwd_new;
  logic                     w_fwd_old;
  logic                     w_final_layer;

  assign neuron_rd_addr = input_neuron_addr;
  assign weight_rd_addr = input_weight_addr;

  assign neuron_wr_en   = r_wr_en;
  assign neuron_wr_addr = r_wr_addr;
  assign neuron_wr_data = r_wr_data;
  assign result_valid   = r_result_valid;
  assign result_data    = r_result_data;
  assign sat_flag       = r_sat;

  // A read matching the value being loaded this cycle takes priority over the
  // older value already sitting in the write register.
  assign w_fwd_new = r_wr && (r_out_addr == input_neuron_addr);
  assign w_fwd_old = r_wr_en && (r_wr_addr == input_neuron_addr);

  assign w_n_op     = r_fwd_sel ? r_fwd_data : neuron_rd_data;
  assign w_n_ext    = {{DATA_W{w_n_op[DATA_W-1]}}, w_n_op};
  assign w_w_ext    = {{DATA_W{weight_rd_data[DATA_W-1]}}, weight_rd_data};
  assign w_prod     = w_n_ext * w_w_ext;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_base     = r_clr_next ? '0 : r_acc;
  assign w_sum      = w_base + w_prod_ext;
  assign w_shift    = w_sum >>> FRAC;
  assign w_final_layer = (r_out_addr[11:10] == 2'b11);

  // Saturate the Q8.8 result, then apply ReLU on hidden layers
  always_comb begin
    w_hi      = (w_shift > SAT_MAX);
    w_lo      = (w_shift < SAT_MIN);
    w_clamped = w_shift[DATA_W-1:0];
    if (w_hi) begin
      w_clamped = SAT_MAX[DATA_W-1:0];
    end else if (w_lo) begin
      w_clamped = SAT_MIN[DATA_W-1:0];
    end
    w_result = w_clamped;
    if (!w_final_layer && w_clamped[DATA_W-1]) begin
      w_result = '0;
    end
  end

  // Align control with read data; an empty slot after reset behaves as a discard
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_acc  <= 1'b1;
      r_wr       <= 1'b0;
      r_done     <= 1'b0;
      r_out_addr <= '0;
      r_fwd_sel  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_rst_acc  <= reset_mult_acc;
      r_wr       <= write_neuron;
      r_done     <= done;
      r_out_addr <= output_neuron_addr;
      r_fwd_sel  <= w_fwd_new || w_fwd_old;
      r_fwd_data <= w_fwd_new ? w_result : r_wr_data;
    end
  end

  // Accumulate terms; a write term ends the neuron so the next sum starts at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc      <= '0;
      r_clr_next <= 1'b1;
    end else if (r_rst_acc && !r_wr) begin
      r_acc <= '0;
    end else begin
      r_acc      <= w_sum;
      r_clr_next <= r_wr;
    end
  end

  // Write register: one-cycle write pulse two cycles after write_neuron
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_final <= 1'b0;
    end else begin
      r_wr_en <= r_wr;
      if (r_wr) begin
        r_wr_addr  <= r_out_addr;
        r_wr_data  <= w_result;
        r_wr_final <= r_done && w_final_layer;
      end
    end
  end

  // Capture the final network output once; it stays until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
    end else if (r_wr_en && r_wr_final && !r_result_valid) begin
      r_result_valid <= 1'b1;
      r_result_data  <= r_wr_data;
    end
  end

  // Sticky saturation indicator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat <= 1'b0;
    end else if (r_wr && (w_hi || w_lo)) begin
      r_sat <= 1'b1;
    end
  end

endmodule

// File: doc/mac_datapath.md
MAC_DATAPATH -- requirements
Module: mac_datapath

Interface
REQ-001 Parameters SHALL be: DATA_W 16, signed neuron/weight width; FRAC 8, fractional bits (Q8.8); ACC_W 40, accumulator width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-004 input_neuron_addr  input  12  neuron memory read address for the current term, from the control unit.
REQ-005 input_weight_addr  input  16  weight memory read address for the current term.
REQ-006 output_neuron_addr  input  12  destination address of the neuron being summed; bits [11:10] give the layer.
REQ-007 reset_mult_acc  input  1  high with write_neuron low: discard the term and clear the accumulator.
REQ-008 write_neuron  input  1  current term is the last term of the neuron.
REQ-009 done  input  1  control unit has issued the final output-layer neuron.
REQ-010 neuron_rd_addr  output  12  neuron memory read address; synchronous memory, 1-cycle read latency.
REQ-011 neuron_rd_data  input  16  neuron memory read data.
REQ-012 weight_rd_addr  output  16  weight memory read address; 1-cycle read latency.
REQ-013 weight_rd_data  input  16  weight memory read data.
REQ-014 neuron_wr_en / neuron_wr_addr / neuron_wr_data  output  1/12/16  neuron memory write port.
REQ-015 result_valid  output  1  final network output available; sticky.
REQ-016 result_data  output  16  final network output, Q8.8.
REQ-017 sat_flag  output  1  sticky flag: a saturation has occurred.

Function
REQ-018 neuron_rd_addr and weight_rd_addr SHALL equal input_neuron_addr and input_weight_addr combinationally (cycle t); the read data is consumed in cycle t+1.
REQ-019 Control inputs sampled in cycle t (reset_mult_acc, write_neuron, output_neuron_addr, done) SHALL be registered once so they align with the data in cycle t+1.
REQ-020 Term in t+1: product = signed(neuron) x signed(weight), 32-bit Q16.16, sign-extended to ACC_W.
REQ-021 Accumulator update at end of t+1: aligned reset_mult_acc=1 and write_neuron=0 -> acc=0, term discarded; else acc = (clr_next ? 0 : acc) + product.
REQ-022 clr_next SHALL be set after any write term and after reset, and cleared after the next accumulated term, so every neuron sum starts from zero.
REQ-023 Aligned write_neuron=1 in t+1: sum = acc_base + product; result = sum >>> FRAC (arithmetic shift), saturated to [-32768, 32767]; any clamp sets sat_flag.
REQ-024 Activation: layer field != 2'b11 -> ReLU (negative -> 0); layer 2'b11 -> linear.
REQ-025 The write register SHALL load at end of t+1: neuron_wr_en=1 for exactly cycle t+2, with the delayed output_neuron_addr; write_neuron sampled in t -> write in t+2.
REQ-026 Forwarding: a read issued in cycle c whose neuron_rd_addr equals the write-register address (write in cycle c, or loading at end of c) SHALL consume the forwarded value in c+1, not memory data.
REQ-027 A write to layer 2'b11 with aligned done=1 SHALL load result_data with the written value and set result_valid in the cycle after the write; both hold until reset.
REQ-028 Back-to-back write terms (single-term neurons) SHALL each produce one write, with no dropped or merged writes.
REQ-029 Accumulator overflow beyond ACC_W SHALL wrap (not a supported operating point); only REQ-023 saturation is flagged.

Reset
REQ-030 reset=0 SHALL immediately clear: acc, pipeline registers, neuron_wr_en, neuron_wr_addr, neuron_wr_data, result_valid, result_data, sat_flag; clr_next=1.
REQ-031 Reset asserted mid-sum or mid-write SHALL cancel any pending write; no write occurs after reset is released until a new write_neuron term completes.

Verification
REQ-032 Sum: 4 terms, neuron 1.0 (0x0100) x weights 0x0100,0x0200,0xFF00,0x0080, last with write_neuron, layer 1 -> one write, data 0x0280, exactly 2 cycles after write_neuron.
REQ-033 ReLU/linear: sum -2.5 written to layer 1 -> data 0x0000; same sum to layer 3 with done -> data 0xFD80, result_valid=1 next cycle, sticky.
REQ-034 Saturation: 16 terms of 0x7F00 x 0x7F00 -> data 0x7FFF, sat_flag=1; negated weights -> data 0x8000 in layer 3.
REQ-035 Forwarding: write 0x0300 to addr 0x400, same cycle read 0x400 with weight 0x0100 -> term contributes 3.0, not the stale memory value.
REQ-036 Reset mid-sum: reset low 1 cycle during term 2 of 4 -> no write; next full neuron sum is correct from zero; single-term neurons back-to-back -> one write each.
